// File: rtl/painterengine_gpu_dma_reader.sv
// AXI4 read master for the GPU DMA path: streams words from memory to one of four channels.
// Optional macro PAINTERENGINE_GPU_READER_SKID_EN inserts a 2-entry skid FIFO between R and the consumer.
module painterengine_gpu_dma_reader #(
  parameter int unsigned PARAM_DATA_ALIGN = 32,
  parameter int unsigned PARAM_TIMEOUT    = 256
) (
  input  logic         i_wire_clock,
  input  logic         i_wire_reset,
  input  logic [3:0]   i_wire_router,
  output logic         o_wire_done,
  input  logic [127:0] i_wire_address,
  input  logic [127:0] i_wire_length,
  output logic [127:0] o_wire_data,
  output logic [3:0]   o_wire_data_valid,
  input  logic [3:0]   i_wire_data_next,
  output logic         o_wire_error,
  output logic [2:0]   o_wire_error_type,
  output logic         o_wire_M_AXI_ARID,
  output logic [31:0]  o_wire_M_AXI_ARADDR,
  output logic [7:0]   o_wire_M_AXI_ARLEN,
  output logic [2:0]   o_wire_M_AXI_ARSIZE,
  output logic [1:0]   o_wire_M_AXI_ARBURST,
  output logic         o_wire_M_AXI_ARLOCK,
  output logic [3:0]   o_wire_M_AXI_ARCACHE,
  output logic [2:0]   o_wire_M_AXI_ARPROT,
  output logic [3:0]   o_wire_M_AXI_ARQOS,
  output logic         o_wire_M_AXI_ARVALID,
  input  logic         i_wire_M_AXI_ARREADY,
  input  logic         i_wire_M_AXI_RID,
  input  logic [31:0]  i_wire_M_AXI_RDATA,
  input  logic [1:0]   i_wire_M_AXI_RRESP,
  input  logic         i_wire_M_AXI_RLAST,
  input  logic         i_wire_M_AXI_RVALID,
  output logic         o_wire_M_AXI_RREADY
);

  localparam int unsigned DW = PARAM_DATA_ALIGN;
  localparam int unsigned TW = $clog2(PARAM_TIMEOUT + 1);

  typedef enum logic [4:0] {
    ST_ROUTING     = 5'h01,
    ST_PARAM_CHECK = 5'h02,
    ST_CALC        = 5'h03,
    ST_ADDR        = 5'h04,
    ST_DATA        = 5'h05,
    ST_DONE        = 5'h07,
    ST_ERR_ROUTING = 5'h10,
    ST_ERR_ALIGN   = 5'h11,
    ST_ERR_LENGTH  = 5'h12,
    ST_ERR_AR      = 5'h13,
    ST_ERR_DATA    = 5'h14
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q;
  logic [31:0]     addr_q, len_q, offset_q, waddr_q;
  logic [8:0]      burstlen_q, beat_q;
  logic [7:0]      arlen_q;
  logic [TW-1:0]   timer_q;
  logic            arvalid_q, done_q;
  logic [2:0]      err_type_q, err_type_d;

  logic            router_onehot;
  logic [1:0]      router_idx;
  logic [31:0]     calc_waddr, remain, room, new_offset;
  logic [8:0]      calc_burst;
  logic            sel_next, beat_last, rready, r_fire, resp_err, last_err;
  logic            burst_done, out_valid, r_idle, ar_timeout, r_timeout;
  logic [DW-1:0]   out_word;
  logic            unused_r;

  assign unused_r = ^{i_wire_M_AXI_RID, i_wire_M_AXI_RRESP[0]};

  // Channel decode and burst sizing (clip at remaining length and the next 1 KiB boundary)
  always_comb begin
    router_idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (i_wire_router[i]) router_idx = 2'(i);
    end
  end
  assign router_onehot = (i_wire_router != '0) && ((i_wire_router & (i_wire_router - 4'd1)) == '0);
  assign calc_waddr    = addr_q + {offset_q[29:0], 2'b00};
  assign remain        = len_q - offset_q;
  assign room          = 32'd256 - {24'd0, calc_waddr[9:2]};
  assign calc_burst    = (remain < room) ? remain[8:0] : room[8:0];
  assign new_offset    = offset_q + {23'd0, burstlen_q};
  assign sel_next      = i_wire_data_next[idx_q];
  assign beat_last     = (beat_q == burstlen_q - 9'd1);
  assign r_fire        = i_wire_M_AXI_RVALID && rready;
  assign resp_err      = r_fire && i_wire_M_AXI_RRESP[1];
  assign last_err      = r_fire && (i_wire_M_AXI_RLAST != beat_last);
  assign ar_timeout    = !i_wire_M_AXI_ARREADY && (timer_q == TW'(PARAM_TIMEOUT - 1));
  assign r_timeout     = r_idle && (timer_q == TW'(PARAM_TIMEOUT - 1));

`ifdef PAINTERENGINE_GPU_READER_SKID_EN
  logic [DW-1:0] fifo_mem [2];
  logic          fifo_wr, fifo_rd, last_seen_q, fifo_pop;
  logic [1:0]    fifo_cnt;

  assign rready     = (state_q == ST_DATA) && (fifo_cnt != 2'd2) && !last_seen_q;
  assign out_valid  = (state_q == ST_DATA) && (fifo_cnt != 2'd0);
  assign fifo_pop   = out_valid && sel_next;
  assign out_word   = fifo_mem[fifo_rd];
  assign burst_done = last_seen_q && (fifo_cnt == 2'd0);
  assign r_idle     = !i_wire_M_AXI_RVALID && !last_seen_q;

  // Skid FIFO; emptied at the start of every burst
  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset || state_q == ST_CALC) begin
      fifo_wr     <= 1'b0;
      fifo_rd     <= 1'b0;
      fifo_cnt    <= 2'd0;
      last_seen_q <= 1'b0;
    end else begin
      if (r_fire) begin
        fifo_mem[fifo_wr] <= i_wire_M_AXI_RDATA;
        fifo_wr           <= ~fifo_wr;
      end
      if (fifo_pop) fifo_rd <= ~fifo_rd;
      fifo_cnt <= fifo_cnt + 2'(r_fire) - 2'(fifo_pop);
      if (r_fire && beat_last) last_seen_q <= 1'b1;
    end
  end
`else
  assign rready     = (state_q == ST_DATA) && sel_next;
  assign out_valid  = (state_q == ST_DATA) && i_wire_M_AXI_RVALID;
  assign out_word   = i_wire_M_AXI_RDATA;
  assign burst_done = r_fire && beat_last;
  assign r_idle     = !i_wire_M_AXI_RVALID;
`endif

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) state_q <= ST_ROUTING;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    err_type_d = err_type_q;
    case (state_q)
      ST_ROUTING: begin
        if (router_onehot) state_d = ST_PARAM_CHECK;
        else if (i_wire_router != '0) begin
          state_d = ST_ERR_ROUTING; err_type_d = 3'd1;
        end
      end
      ST_PARAM_CHECK: begin
        if (addr_q[1:0] != 2'd0) begin
          state_d = ST_ERR_ALIGN; err_type_d = 3'd2;
        end else if (len_q == '0) begin
          state_d = ST_ERR_LENGTH; err_type_d = 3'd3;
        end else state_d = ST_CALC;
      end
      ST_CALC: state_d = ST_ADDR;
      ST_ADDR: begin
        if (i_wire_M_AXI_ARREADY) state_d = ST_DATA;
        else if (ar_timeout) begin
          state_d = ST_ERR_AR; err_type_d = 3'd4;
        end
      end
      ST_DATA: begin
        if (resp_err || last_err || r_timeout) begin
          state_d    = ST_ERR_DATA;
          err_type_d = resp_err ? 3'd5 : 3'd6;
        end else if (burst_done) begin
          state_d = (new_offset >= len_q) ? ST_DONE : ST_CALC;
        end
      end
      ST_DONE: if (i_wire_router == '0) state_d = ST_ROUTING;
      ST_ERR_ROUTING, ST_ERR_ALIGN, ST_ERR_LENGTH, ST_ERR_AR, ST_ERR_DATA: state_d = state_q;
      default: state_d = ST_ROUTING;
    endcase
  end

  // Transfer bookkeeping and registered AR/status outputs
  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      idx_q <= '0; addr_q <= '0; len_q <= '0; offset_q <= '0; waddr_q <= '0;
      burstlen_q <= '0; beat_q <= '0; arlen_q <= '0; timer_q <= '0;
      arvalid_q <= 1'b0; done_q <= 1'b0; err_type_q <= '0;
    end else begin
      arvalid_q  <= (state_d == ST_ADDR);
      done_q     <= (state_d == ST_DONE);
      err_type_q <= err_type_d;
      case (state_q)
        ST_ROUTING: if (router_onehot) begin
          idx_q    <= router_idx;
          addr_q   <= i_wire_address[{router_idx, 5'd0} +: 32];
          len_q    <= i_wire_length[{router_idx, 5'd0} +: 32];
          offset_q <= '0;
        end
        ST_CALC: begin
          waddr_q    <= calc_waddr;
          burstlen_q <= calc_burst;
          arlen_q    <= 8'(calc_burst - 9'd1);
          timer_q    <= '0;
          beat_q     <= '0;
        end
        ST_ADDR: begin
          if (i_wire_M_AXI_ARREADY) begin
            timer_q <= '0;
            beat_q  <= '0;
          end else timer_q <= timer_q + TW'(1);
        end
        ST_DATA: begin
          if (r_fire) beat_q <= beat_q + 9'd1;
          if (i_wire_M_AXI_RVALID) timer_q <= '0;
          else if (r_idle) timer_q <= timer_q + TW'(1);
          if (state_d == ST_DONE || state_d == ST_CALC) offset_q <= new_offset;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_wire_data       = '0;
    o_wire_data_valid = '0;
    if (state_q == ST_DATA) begin
      o_wire_data[{idx_q, 5'd0} +: 32] = out_word;
      o_wire_data_valid[idx_q]         = out_valid;
    end
  end

  assign o_wire_M_AXI_ARID    = 1'b0;
  assign o_wire_M_AXI_ARADDR  = waddr_q;
  assign o_wire_M_AXI_ARLEN   = arlen_q;
  assign o_wire_M_AXI_ARSIZE  = 3'b010;
  assign o_wire_M_AXI_ARBURST = 2'b01;
  assign o_wire_M_AXI_ARLOCK  = 1'b0;
  assign o_wire_M_AXI_ARCACHE = 4'b0010;
  assign o_wire_M_AXI_ARPROT  = 3'b000;
  assign o_wire_M_AXI_ARQOS   = 4'b0000;
  assign o_wire_M_AXI_ARVALID = arvalid_q;
  assign o_wire_M_AXI_RREADY  = rready;
  assign o_wire_done          = done_q;
  assign o_wire_error         = state_q[4];
  assign o_wire_error_type    = err_type_q;

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Directed bench for painterengine_gpu_dma_reader with a single-outstanding AXI read slave model.
module tb_painterengine_gpu_dma_reader;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   router = '0;
  logic [127:0] address = '0, length = '0;
  logic [3:0]   data_next = '0;
  logic         arready = 1'b0, rid = 1'b0, rlast = 1'b0, rvalid = 1'b0;
  logic [31:0]  rdata = '0;
  logic [1:0]   rresp = '0;
  logic         done, error, arid, arvalid, arlock, rready;
  logic [127:0] data;
  logic [3:0]   data_valid, arcache, arqos;
  logic [2:0]   error_type, arsize, arprot;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [1:0]   arburst;

  painterengine_gpu_dma_reader dut (
    .i_wire_clock(clk), .i_wire_reset(rst), .i_wire_router(router), .o_wire_done(done),
    .i_wire_address(address), .i_wire_length(length), .o_wire_data(data),
    .o_wire_data_valid(data_valid), .i_wire_data_next(data_next), .o_wire_error(error),
    .o_wire_error_type(error_type), .o_wire_M_AXI_ARID(arid), .o_wire_M_AXI_ARADDR(araddr),
    .o_wire_M_AXI_ARLEN(arlen), .o_wire_M_AXI_ARSIZE(arsize), .o_wire_M_AXI_ARBURST(arburst),
    .o_wire_M_AXI_ARLOCK(arlock), .o_wire_M_AXI_ARCACHE(arcache), .o_wire_M_AXI_ARPROT(arprot),
    .o_wire_M_AXI_ARQOS(arqos), .o_wire_M_AXI_ARVALID(arvalid), .i_wire_M_AXI_ARREADY(arready),
    .i_wire_M_AXI_RID(rid), .i_wire_M_AXI_RDATA(rdata), .i_wire_M_AXI_RRESP(rresp),
    .i_wire_M_AXI_RLAST(rlast), .i_wire_M_AXI_RVALID(rvalid), .o_wire_M_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int cur_ch = 0, toggle_next = 0, gap_pct = 0, inj_resp = -1, inj_last = -1, chg_at = -1;
  bit arready_en = 1'b1, ar_fire_s, r_fire_s, s_active, slice_bad, ar_gap_bad, timed_out, arvalid_prev;
  logic [31:0] s_addr;
  int s_len, s_beat, cyc = 0, last_rlast_cyc = -100;
  logic [31:0] ar_addr_log[$];
  logic [7:0]  ar_len_log[$];
  logic [31:0] got[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // One clock: drive slave/consumer at negedge, observe handshakes just before the rising edge
  task automatic cycle();
    logic [127:0] tmp;
    @(negedge clk);
    cyc++;
    arready = arready_en;
    if (!(rvalid && !r_fire_s)) rvalid = s_active && ($urandom_range(0, 99) >= gap_pct);
    rdata = word_of(s_addr + 32'(s_beat * 4));
    rlast = (s_beat == s_len - 1) || (s_beat == inj_last);
    rresp = (s_beat == inj_resp) ? 2'b10 : 2'b00;
    if (toggle_next != 0) data_next = ~data_next;
    else data_next = 4'hF;
    #4;
    ar_fire_s = arvalid && arready;
    r_fire_s  = rvalid && rready;
    if (arvalid && !arvalid_prev && (cyc - last_rlast_cyc) < 2) ar_gap_bad = 1'b1;
    arvalid_prev = arvalid;
    if (ar_fire_s) begin
      ar_addr_log.push_back(araddr);
      ar_len_log.push_back(arlen);
      s_active = 1'b1; s_addr = araddr; s_len = int'(arlen) + 1; s_beat = 0;
    end
    if (r_fire_s) begin
      if (rlast) last_rlast_cyc = cyc;
      s_beat++;
      if (s_beat == s_len) s_active = 1'b0;
    end
    if (data_valid[cur_ch] && data_next[cur_ch]) got.push_back(data[cur_ch*32 +: 32]);
    tmp = data;
    tmp[cur_ch*32 +: 32] = '0;
    if (tmp != '0 || (data_valid & ~(4'(1) << cur_ch)) != '0) slice_bad = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; router = '0; rvalid = 1'b0; s_active = 1'b0; s_len = 0; s_beat = 0; s_addr = '0;
    r_fire_s = 1'b0; ar_fire_s = 1'b0;
    repeat (3) cycle();
    rst = 1'b0;
    ar_addr_log.delete(); ar_len_log.delete(); got.delete();
    slice_bad = 1'b0; ar_gap_bad = 1'b0; last_rlast_cyc = -100; timed_out = 1'b0;
  endtask

  task automatic run_xfer(input int ch, input logic [31:0] addr, input logic [31:0] len, input int budget);
    int n;
    do_reset();
    address = '0; length = '0;
    address[ch*32 +: 32] = addr;
    length[ch*32 +: 32]  = len;
    cur_ch = ch;
    router = 4'(1) << ch;
    n = 0;
    while (!(done || error)) begin
      if (n >= budget) begin timed_out = 1'b1; break; end
      if (n == chg_at) router = 4'b1000;
      cycle();
      n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (arvalid !== 1'b0) begin miscompares++; $display("FAIL reset_arvalid got %b want 0", arvalid); end
    vectors++; if (rready !== 1'b0) begin miscompares++; $display("FAIL reset_rready got %b want 0", rready); end
    vectors++; if (data_valid !== 4'h0) begin miscompares++; $display("FAIL reset_valid got %h want 0", data_valid); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error got %b want 0", error); end
    vectors++; if (error_type !== 3'd0) begin miscompares++; $display("FAIL reset_type got %0d want 0", error_type); end
    vectors++; if (data !== 128'd0) begin miscompares++; $display("FAIL reset_data got %h want 0", data); end
  endtask

  task automatic test_single();
    run_xfer(1, 32'h1000, 32'd8, 300);
    vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("FAIL single_timeout got %b want 0", timed_out); end
    vectors++; if (ar_addr_log.size() !== 1) begin miscompares++; $display("FAIL single_ar_count got %0d want 1", ar_addr_log.size()); end
    if (ar_addr_log.size() >= 1) begin
      vectors++; if (ar_addr_log[0] !== 32'h1000) begin miscompares++; $display("FAIL single_araddr got %h want 1000", ar_addr_log[0]); end
      vectors++; if (ar_len_log[0] !== 8'd7) begin miscompares++; $display("FAIL single_arlen got %0d want 7", ar_len_log[0]); end
    end
    vectors++; if ({arid, arsize, arburst, arlock, arcache, arprot, arqos} !== {1'b0, 3'b010, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000})
      begin miscompares++; $display("FAIL single_ar_const got %b", {arid, arsize, arburst, arlock, arcache, arprot, arqos}); end
    vectors++; if (got.size() !== 8) begin miscompares++; $display("FAIL single_words got %0d want 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      vectors++; if (got[i] !== word_of(32'h1000 + 32'(i * 4))) begin miscompares++; $display("FAIL single_word%0d got %h want %h", i, got[i], word_of(32'h1000 + 32'(i * 4))); end
    end
    vectors++; if (slice_bad !== 1'b0) begin miscompares++; $display("FAIL single_slices got %b want 0", slice_bad); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL single_done got %b want 1", done); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL single_error got %b want 0", error); end
    router = '0;
    repeat (2) cycle();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL single_done_clear got %b want 0", done); end
  endtask

  task automatic test_multi_burst();
    logic [31:0] ea [3];
    logic [7:0]  el [3];
    ea = '{32'h3F8, 32'h400, 32'h800};
    el = '{8'd1, 8'd255, 8'd41};
    run_xfer(0, 32'h3F8, 32'd300, 3000);
    vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("FAIL multi_timeout got %b want 0", timed_out); end
    vectors++; if (ar_addr_log.size() !== 3) begin miscompares++; $display("FAIL multi_ar_count got %0d want 3", ar_addr_log.size()); end
    for (int i = 0; i < ar_addr_log.size() && i < 3; i++) begin
      vectors++; if (ar_addr_log[i] !== ea[i] || ar_len_log[i] !== el[i]) begin miscompares++;
        $display("FAIL multi_ar%0d got %h/%0d want %h/%0d", i, ar_addr_log[i], ar_len_log[i], ea[i], el[i]); end
    end
    vectors++; if (got.size() !== 300) begin miscompares++; $display("FAIL multi_words got %0d want 300", got.size()); end
    for (int i = 0; i < got.size() && i < 300; i++) begin
      vectors++; if (got[i] !== word_of(32'h3F8 + 32'(i * 4))) begin miscompares++; $display("FAIL multi_word%0d got %h want %h", i, got[i], word_of(32'h3F8 + 32'(i * 4))); end
    end
    vectors++; if (ar_gap_bad !== 1'b0) begin miscompares++; $display("FAIL multi_ar_gap got %b want 0", ar_gap_bad); end
    vectors++; if ({done, error} !== 2'b10) begin miscompares++; $display("FAIL multi_status got %b want 10", {done, error}); end
  endtask

  task automatic test_boundary();
    run_xfer(2, 32'h3FC, 32'd4, 300);
    vectors++; if (ar_addr_log.size() !== 2) begin miscompares++; $display("FAIL bnd_ar_count got %0d want 2", ar_addr_log.size()); end
    if (ar_addr_log.size() == 2) begin
      vectors++; if ({ar_addr_log[0], ar_len_log[0]} !== {32'h3FC, 8'd0}) begin miscompares++; $display("FAIL bnd_ar0 got %h/%0d want 3fc/0", ar_addr_log[0], ar_len_log[0]); end
      vectors++; if ({ar_addr_log[1], ar_len_log[1]} !== {32'h400, 8'd2}) begin miscompares++; $display("FAIL bnd_ar1 got %h/%0d want 400/2", ar_addr_log[1], ar_len_log[1]); end
    end
    vectors++; if (got.size() !== 4) begin miscompares++; $display("FAIL bnd_words got %0d want 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      vectors++; if (got[i] !== word_of(32'h3FC + 32'(i * 4))) begin miscompares++; $display("FAIL bnd_word%0d got %h want %h", i, got[i], word_of(32'h3FC + 32'(i * 4))); end
    end
    run_xfer(3, 32'h400, 32'd256, 1500);
    vectors++; if (ar_len_log.size() !== 1) begin miscompares++; $display("FAIL full_ar_count got %0d want 1", ar_len_log.size()); end
    if (ar_len_log.size() == 1) begin
      vectors++; if (ar_len_log[0] !== 8'd255) begin miscompares++; $display("FAIL full_arlen got %0d want 255", ar_len_log[0]); end
    end
    vectors++; if (got.size() !== 256) begin miscompares++; $display("FAIL full_words got %0d want 256", got.size()); end
    if (got.size() == 256) begin
      vectors++; if (got[255] !== word_of(32'h7FC)) begin miscompares++; $display("FAIL full_last got %h want %h", got[255], word_of(32'h7FC)); end
    end
    vectors++; if ({done, error, slice_bad} !== 3'b100) begin miscompares++; $display("FAIL full_status got %b want 100", {done, error, slice_bad}); end
  endtask

  task automatic test_param_errors();
    logic [3:0]  rt [3];
    logic [31:0] ad [3];
    logic [31:0] ln [3];
    rt = '{4'b0011, 4'b0001, 4'b0001};
    ad = '{32'h1000, 32'h1002, 32'h1000};
    ln = '{32'd4, 32'd4, 32'd0};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      cur_ch = 0;
      address = {96'd0, ad[k]};
      length  = {96'd0, ln[k]};
      router  = rt[k];
      repeat (10) cycle();
      vectors++; if ({error, error_type} !== {1'b1, 3'(k + 1)}) begin miscompares++; $display("FAIL perr%0d got %b/%0d want 1/%0d", k, error, error_type, k + 1); end
      router = '0;
      repeat (30) cycle();
      vectors++; if ({error, error_type, arvalid} !== {1'b1, 3'(k + 1), 1'b0}) begin miscompares++; $display("FAIL perr%0d_hold got %b/%0d/%b want 1/%0d/0", k, error, error_type, arvalid, k + 1); end
    end
  endtask

  task automatic test_ar_timeout();
    do_reset();
    arready_en = 1'b0;
    cur_ch = 0;
    address = {96'd0, 32'h1000};
    length  = {96'd0, 32'd4};
    router  = 4'b0001;
    repeat (200) cycle();
    vectors++; if ({arvalid, error} !== 2'b10) begin miscompares++; $display("FAIL ar_wait got %b want 10", {arvalid, error}); end
    repeat (100) cycle();
    vectors++; if ({error, error_type, arvalid} !== {1'b1, 3'd4, 1'b0}) begin miscompares++; $display("FAIL ar_timeout got %b/%0d/%b want 1/4/0", error, error_type, arvalid); end
    arready_en = 1'b1;
  endtask

  task automatic test_r_errors();
    inj_resp = 3;
    run_xfer(0, 32'h2000, 32'd4, 300);
    vectors++; if ({error, error_type} !== {1'b1, 3'd5}) begin miscompares++; $display("FAIL rresp_err got %b/%0d want 1/5", error, error_type); end
    inj_resp = -1;
    inj_last = 1;
    run_xfer(0, 32'h2000, 32'd4, 300);
    vectors++; if ({error, error_type} !== {1'b1, 3'd6}) begin miscompares++; $display("FAIL rlast_err got %b/%0d want 1/6", error, error_type); end
    inj_last = -1;
    gap_pct = 100;
    run_xfer(0, 32'h2000, 32'd4, 600);
    vectors++; if ({error, error_type, timed_out} !== {1'b1, 3'd6, 1'b0}) begin miscompares++; $display("FAIL r_timeout got %b/%0d/%b want 1/6/0", error, error_type, timed_out); end
    gap_pct = 0;
  endtask

  task automatic test_back_to_back();
    toggle_next = 1; gap_pct = 30; chg_at = 50;
    run_xfer(2, 32'h0010_0000, 32'd512, 8000);
    vectors++; if ({timed_out, error, done} !== 3'b001) begin miscompares++; $display("FAIL stream_status got %b want 001", {timed_out, error, done}); end
    vectors++; if (ar_addr_log.size() !== 2) begin miscompares++; $display("FAIL stream_ar_count got %0d want 2", ar_addr_log.size()); end
    if (ar_addr_log.size() == 2) begin
      vectors++; if ({ar_addr_log[1], ar_len_log[1]} !== {32'h0010_0400, 8'd255}) begin miscompares++; $display("FAIL stream_ar1 got %h/%0d want 100400/255", ar_addr_log[1], ar_len_log[1]); end
    end
    vectors++; if (got.size() !== 512) begin miscompares++; $display("FAIL stream_words got %0d want 512", got.size()); end
    for (int i = 0; i < got.size() && i < 512; i++) begin
      vectors++; if (got[i] !== word_of(32'h0010_0000 + 32'(i * 4))) begin miscompares++; $display("FAIL stream_word%0d got %h want %h", i, got[i], word_of(32'h0010_0000 + 32'(i * 4))); end
    end
    vectors++; if (slice_bad !== 1'b0) begin miscompares++; $display("FAIL stream_slices got %b want 0", slice_bad); end
    toggle_next = 0; gap_pct = 0; chg_at = -1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_burst();
    test_boundary();
    test_param_errors();
    test_ar_timeout();
    test_r_errors();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/painterengine_gpu_dma_reader.md
Name: painterengine_gpu_dma_reader

Overview:
AXI4 full read master for the GPU DMA path; the read-side counterpart of the GPU DMA writer. It selects one of four channel descriptors (address, length in 32-bit words) via a one-hot router and streams the words read from memory to that channel through a valid/next handshake. Requests are split into INCR bursts of at most 256 beats, and no burst crosses a 1 KiB boundary. It reports done, or a sticky error with a type code.

Parameters:
PARAM_DATA_ALIGN, 32, data word width in bits; only 32 is supported.
PARAM_TIMEOUT, 256, idle-cycle limit for the AR handshake and for R-channel silence.

Ports:
i_wire_clock  in  1  clock
i_wire_reset  in  1  synchronous, active-high reset
i_wire_router  in  4  one-hot channel select; 0 = idle
o_wire_done  out  1  high in DONE
i_wire_address  in  128  four 32-bit byte addresses; channel n at [n*32+:32]
i_wire_length  in  128  four 32-bit lengths, in words
o_wire_data  out  128  read word, driven on the selected channel slice; other slices 0
o_wire_data_valid  out  4  word valid, selected channel only
i_wire_data_next  in  4  consumer accepts the word this cycle
o_wire_error  out  1  state[4]
o_wire_error_type  out  3  0 ok, 1 routing, 2 align, 3 length, 4 AR timeout, 5 RRESP, 6 RLAST/R timeout
o_wire_M_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT/ARQOS/ARVALID  out  1/32/8/3/2/1/4/3/4/1  AR channel
i_wire_M_AXI_ARREADY  in  1
i_wire_M_AXI_RID/RDATA/RRESP/RLAST/RVALID  in  1/32/2/1/1  R channel
o_wire_M_AXI_RREADY  out  1

Behaviour:
- Reset: synchronous; state ROUTING, all counters 0. ARVALID=0, RREADY=0, data_valid=0, done=0, error=0, error_type=0. A reset during a burst abandons it immediately; the interconnect is reset alongside the block.
- Constant AR fields: ARID=0, ARSIZE=3'b010, ARBURST=2'b01, ARLOCK=0, ARCACHE=4'b0010, ARPROT=0, ARQOS=0. ARLEN=burstlen-1.
- States (5-bit): ROUTING 01, PARAM_CHECK 02, CALC 03, ADDR 04, DATA 05, DONE 07, ERR_ROUTING 10, ERR_ALIGN 11, ERR_LENGTH 12, ERR_AR 13, ERR_DATA 14.
- ROUTING: router==0 -> stay. Exactly one bit set -> latch index, address and length; offset=0; go to PARAM_CHECK. Any other value -> ERR_ROUTING.
- PARAM_CHECK: address[1:0]!=0 -> ERR_ALIGN. Length==0 -> ERR_LENGTH. Otherwise CALC.
- CALC (1 cycle):
  - waddr = address + offset*4.
  - burstlen (9 bits) = min(256 - waddr[9:2], length - offset).
  - Go to ADDR.
- ADDR: ARVALID=1 with ARADDR=waddr. On ARVALID&&ARREADY: drop ARVALID, beat=0, go to DATA. Counts idle cycles; reaching PARAM_TIMEOUT -> ERR_AR.
- DATA, no skid buffer:
  - RREADY = i_wire_data_next[idx]; data_valid[idx] = RVALID; data = RDATA.
  - Beat accepted on RVALID&&RREADY; beat increments.
  - RRESP>=2 on an accepted beat -> ERR_DATA.
  - RLAST must equal (beat==burstlen-1); mismatch -> ERR_DATA.
  - On the last beat: offset += burstlen; then DONE if offset>=length, else CALC.
  - Timeout counts only cycles with RVALID=0 and resets on any RVALID. Reaching PARAM_TIMEOUT -> ERR_DATA. Consumer back-pressure never times out.
- Only one burst is outstanding at a time; the next AR is issued at least 2 cycles after the previous RLAST.
- DONE: done=1 while router!=0; router==0 -> ROUTING.
- Error states are sticky until reset. error_type is set on entry and holds.
- Boundaries:
  - Address 0x3FC, length 4 -> bursts of 1 then 3.
  - Length 256 at 0x400 -> one burst, ARLEN=255.
  - Length > 256 -> multiple bursts.
  - A router change mid-transfer is ignored until ROUTING.

Optional Feature:
PAINTERENGINE_GPU_READER_SKID_EN. When defined, a 2-entry FIFO sits between R and the consumer:
- RREADY = FIFO not full.
- Consumer side: data_valid = FIFO not empty; pop on next.
- Data latency is 1 cycle after the R handshake.
- Burst completion, and the transition to DONE/CALC, waits for the FIFO to drain.
- RRESP/RLAST checks occur at the R handshake.
When undefined: combinational pass-through as in Behaviour, zero latency.

Test Plan:
- Router=4'b0010, addr 0x1000, len 8, next tied 1, ideal slave -> one AR (ARADDR 0x1000, ARLEN 7); 8 words on o_wire_data[63:32]; done=1; error=0.
- Router=4'b0001, addr 0x3F8, len 300 -> three ARs: 0x3F8/ARLEN 1, 0x400/ARLEN 255, 0x800/ARLEN 41; 300 words in order; done.
- Router=4'b0011 -> ERR_ROUTING, type 1. Addr 0x1002 -> type 2. Len 0 -> type 3. Each held until reset.
- ARREADY held 0 -> ARVALID held high; after 256 cycles error=1, type 4.
- RRESP=2'b10 on beat 3, or RLAST asserted on beat 2 of 4 -> error type 5 or 6 respectively.
- Consumer next toggling 1/0 with random RVALID gaps, 512 words -> data in order with no drop or duplicate, no timeout. Repeat with and without the skid-buffer macro.
